// File: rtl/ext_intr_router.sv
// ext_intr_router
//
// Interrupt aggregator and router. Collects NUM_SRC external interrupt
// sources, gives each one a level or rising-edge mode, an enable bit, a
// latched pending bit and a route index, and drives NUM_OUT registered
// interrupt lines plus one fast-interrupt line that is the OR of them.
//
// Optional build macro: EXT_INTR_ROUTER_SYNC_EN
//   defined   : src_i passes a 2-flop synchroniser before src_q
//               (source -> intr_o latency 5 edges)
//   undefined : src_i is assumed synchronous to clk_i (latency 3 edges)
//
// Register map (low 8 address bits decoded, bits >= NUM_SRC read as 0):
//   0x00       ENABLE   RW
//   0x04       MODE     RW  0 = level, 1 = rising edge
//   0x08       PENDING  RO for level sources, W1C for edge sources
//   0x0C       STATUS   RO  PENDING & ENABLE
//   0x10+4k    ROUTE_k  RW  bits [OUT_IDX_W-1:0]; a written value >= NUM_OUT
//                            routes source k nowhere
//   other      reg_error_o = 1, rdata 0, write ignored
//
// Bus handshake: a request is presented by raising reg_valid_i; it is always
// accepted in the same cycle (reg_ready_o mirrors reg_valid_i). Read data and
// error are combinational from current state; writes land on the next clock
// edge and only when all four byte strobes are set.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   src_i[NUM_SRC]         raw interrupt sources
//   reg_valid_i/write_i/addr_i/wdata_i/wstrb_i   register request
//   reg_rdata_o/ready_o/error_o                  register response
//   intr_o[NUM_OUT]        routed interrupt lines
//   fast_intr_o            OR of all routed lines
module ext_intr_router #(
    parameter int NUM_SRC = 4,
    parameter int NUM_OUT = 4,
    localparam int OUT_IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               reg_valid_i,
    input  logic               reg_write_i,
    input  logic [31:0]        reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    input  logic [3:0]         reg_wstrb_i,
    output logic [31:0]        reg_rdata_o,
    output logic               reg_ready_o,
    output logic               reg_error_o,
    output logic [NUM_OUT-1:0] intr_o,
    output logic               fast_intr_o
);

    // ------------------------------------------------------------------
    // Source input path
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] src_in;

`ifdef EXT_INTR_ROUTER_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_in = sync_q2;
`else
    assign src_in = src_i;
`endif

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            src_prev <= '0;
        end else begin
            src_q    <= src_in;
            src_prev <= src_q;
        end
    end

    assign rise = src_q & ~src_prev;

    // ------------------------------------------------------------------
    // Configuration state
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]   enable_q;
    logic [NUM_SRC-1:0]   mode_q;
    logic [NUM_SRC-1:0]   pending_q;
    logic [OUT_IDX_W-1:0] route_idx_q [NUM_SRC];
    // Cleared when the written route value is >= NUM_OUT, so out-of-range
    // routes stay silent even when NUM_OUT is a power of two and the stored
    // index bits alone could not express "nowhere".
    logic [NUM_SRC-1:0]   route_ok_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [7:0]         offset;
    logic               sel_enable;
    logic               sel_mode;
    logic               sel_pending;
    logic               sel_status;
    logic [NUM_SRC-1:0] route_hit;
    logic               mapped;
    logic               wr_ok;
    logic               unused_addr_bits;

    assign offset           = reg_addr_i[7:0];
    assign unused_addr_bits = ^reg_addr_i[31:8];

    always_comb begin
        route_hit = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            route_hit[k] = (offset == 8'(16 + 4 * k));
        end
    end

    assign sel_enable  = (offset == 8'h00);
    assign sel_mode    = (offset == 8'h04);
    assign sel_pending = (offset == 8'h08);
    assign sel_status  = (offset == 8'h0C);
    assign mapped      = sel_enable | sel_mode | sel_pending | sel_status | (|route_hit);

    assign wr_ok = reg_valid_i & reg_write_i & (reg_wstrb_i == 4'hF) & mapped;

    // ------------------------------------------------------------------
    // Response path (combinational)
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (sel_enable)  rd_val[NUM_SRC-1:0] = enable_q;
        if (sel_mode)    rd_val[NUM_SRC-1:0] = mode_q;
        if (sel_pending) rd_val[NUM_SRC-1:0] = pending_q;
        if (sel_status)  rd_val[NUM_SRC-1:0] = pending_q & enable_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (route_hit[k]) begin
                rd_val[OUT_IDX_W-1:0] = rd_val[OUT_IDX_W-1:0] | route_idx_q[k];
            end
        end
    end

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i & ~mapped;
    assign reg_rdata_o = (reg_valid_i && !reg_write_i) ? rd_val : 32'h0;

    // ------------------------------------------------------------------
    // Pending update
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] pending_d;

    assign w1c = (wr_ok && sel_pending) ? reg_wdata_i[NUM_SRC-1:0] : '0;

    // Level sources track src_q; edge sources latch on rise and clear on W1C,
    // with a simultaneous rise taking priority over the clear.
    assign pending_d = (~mode_q & src_q) |
                       ( mode_q & (rise | (pending_q & ~w1c)));

    // ------------------------------------------------------------------
    // Routing
    // ------------------------------------------------------------------
    logic [NUM_OUT-1:0] intr_d;

    always_comb begin
        intr_d = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (pending_q[k] && enable_q[k] && route_ok_q[k] &&
                    (route_idx_q[k] == OUT_IDX_W'(j))) begin
                    intr_d[j] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pending_q   <= '0;
            route_ok_q  <= {NUM_SRC{1'b1}};
            intr_o      <= '0;
            fast_intr_o <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                route_idx_q[k] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            intr_o      <= intr_d;
            fast_intr_o <= |intr_d;
            if (wr_ok && sel_enable) enable_q <= reg_wdata_i[NUM_SRC-1:0];
            if (wr_ok && sel_mode)   mode_q   <= reg_wdata_i[NUM_SRC-1:0];
            for (int k = 0; k < NUM_SRC; k++) begin
                if (wr_ok && route_hit[k]) begin
                    route_idx_q[k] <= reg_wdata_i[OUT_IDX_W-1:0];
                    route_ok_q[k]  <= (reg_wdata_i < 32'(NUM_OUT));
                end
            end
        end
    end

endmodule
